// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and sizes for the data-memory controller and its line storage.
package data_mem_ctrl_pkg;

  localparam int unsigned ADDR_W        = 16;
  localparam int unsigned DATA_W        = 16;
  localparam int unsigned LINES_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

endpackage

// File: rtl/data_mem_ctrl_dcache_array.sv
// Direct-mapped line storage: valid/tag/data arrays.
// Ports:
//   clk, rst                : clock, synchronous active-low reset (valid bits only)
//   rd_idx -> rd_valid/tag/data : combinational read port
//   wr_en, wr_idx, wr_tag, wr_data : synchronous write port (also sets valid)
module dcache_array
  import data_mem_ctrl_pkg::*;
#(
  parameter int unsigned LINES = LINES_DEFAULT,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned TAG_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data
);

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags  [LINES];
  logic [DATA_W-1:0] words [LINES];

  // Only the valid bits are reset; tag/data contents are don't-care until valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx]  <= wr_tag;
      words[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = words[rd_idx];

endmodule

// File: rtl/data_mem_ctrl.sv
// Memory-stage data cache controller: direct-mapped, one word per line,
// write-through without write-allocate, blocking on misses and stores.
// Ports:
//   clk, rst                         : clock, synchronous active-low reset
//   enable, wr, addr, data_in        : CPU request (held stable while stall=1)
//   data_out, stall                  : load data and pipeline hold
//   mem_req/mem_wr/mem_addr/mem_wdata: main-memory request, held until mem_ack
//   mem_rdata, mem_ack               : main-memory response
//   hit_cnt, miss_cnt                : saturating load hit/miss counters
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int unsigned LINES = LINES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = ADDR_W - 1 - IDX_W;

  state_t            state;
  logic [DATA_W-1:0] rdata_q;

  logic [IDX_W-1:0]  rd_idx;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [DATA_W-1:0] rd_data;
  logic              arr_we;
  logic [DATA_W-1:0] arr_wdata;
  logic              hit;

  // mem_addr doubles as the captured request address for the wait states.
  logic [IDX_W-1:0]  cap_idx;
  logic [TAG_W-1:0]  cap_tag;
  assign cap_idx = mem_addr[IDX_W:1];
  assign cap_tag = mem_addr[ADDR_W-1:IDX_W+1];

  dcache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (rd_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (arr_we),
    .wr_idx   (cap_idx),
    .wr_tag   (cap_tag),
    .wr_data  (arr_wdata)
  );

  // Read port looks at the live address in IDLE, the captured one while waiting.
  always_comb begin
    rd_idx    = addr[IDX_W:1];
    arr_we    = 1'b0;
    arr_wdata = mem_rdata;
    if (state != IDLE) begin
      rd_idx = cap_idx;
    end
    if (state == RD_WAIT && mem_ack) begin
      arr_we = 1'b1;
    end
    // Store only refreshes a line that already holds this address.
    if (state == WR_WAIT && mem_ack && rd_valid && (rd_tag == cap_tag)) begin
      arr_we    = 1'b1;
      arr_wdata = mem_wdata;
    end
  end

  assign hit = rd_valid && (rd_tag == addr[ADDR_W-1:IDX_W+1]);

  // Hold and load-data paths are combinational so a hit completes in one cycle.
  always_comb begin
    stall    = 1'b0;
    data_out = '0;
    case (state)
      IDLE: begin
        if (enable && (wr || !hit)) begin
          stall = 1'b1;
        end
        if (enable && !wr && hit) begin
          data_out = rd_data;
        end
      end
      RD_WAIT, WR_WAIT: stall = 1'b1;
      RESP: begin
        if (enable && !wr && !mem_wr) begin
          data_out = rdata_q;
        end
      end
      default: ;
    endcase
  end

  // Controller FSM with registered memory-side outputs and counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata_q   <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            if (wr) begin
              mem_req   <= 1'b1;
              mem_wr    <= 1'b1;
              mem_addr  <= addr & ~ADDR_W'(1);
              mem_wdata <= data_in;
              state     <= WR_WAIT;
            end else if (hit) begin
              if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
            end else begin
              if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
              mem_req   <= 1'b1;
              mem_wr    <= 1'b0;
              mem_addr  <= addr & ~ADDR_W'(1);
              mem_wdata <= data_in;
              state     <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (mem_ack) begin
            rdata_q <= mem_rdata;
            mem_req <= 1'b0;
            state   <= RESP;
          end
        end
        WR_WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= RESP;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl (LINES=16).
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        stall;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int errors = 0;
  int checks = 0;
  int stall_cycles;

  data_mem_ctrl #(.LINES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .wr        (wr),
    .addr      (addr),
    .data_in   (data_in),
    .data_out  (data_out),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic w, input logic [15:0] a, input logic [15:0] d);
    enable  = 1'b1;
    wr      = w;
    addr    = a;
    data_in = d;
    #1;
  endtask

  // One-cycle ack pulse during a wait state; returns in the RESP cycle.
  task automatic ack(input logic [15:0] r);
    mem_ack   = 1'b1;
    mem_rdata = r;
    tick();
    mem_ack   = 1'b0;
    #1;
  endtask

  task automatic finish_resp();
    enable = 1'b0;
    wr     = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick();
    rst = 1'b1;
    #1;
    check("rst_stall", 16'(stall), 16'd0);
    check("rst_req", 16'(mem_req), 16'd0);
    check("rst_hit", hit_cnt, 16'd0);
    check("rst_miss", miss_cnt, 16'd0);
    check("rst_dout", data_out, 16'h0000);

    // First load misses and fills the line.
    start(1'b0, 16'h0040, 16'h0);
    check("miss1_stall_idle", 16'(stall), 16'd1);
    check("miss1_req_idle", 16'(mem_req), 16'd0);
    tick();
    check("miss1_req", 16'(mem_req), 16'd1);
    check("miss1_addr", mem_addr, 16'h0040);
    check("miss1_wr", 16'(mem_wr), 16'd0);
    check("miss1_stall", 16'(stall), 16'd1);
    check("miss1_cnt", miss_cnt, 16'd1);
    ack(16'hBEEF);
    check("miss1_resp_stall", 16'(stall), 16'd0);
    check("miss1_resp_dout", data_out, 16'hBEEF);
    check("miss1_resp_req", 16'(mem_req), 16'd0);

    // Same request held into IDLE now hits.
    tick();
    check("hit1_stall", 16'(stall), 16'd0);
    check("hit1_dout", data_out, 16'hBEEF);
    check("hit1_req", 16'(mem_req), 16'd0);
    tick();
    enable = 1'b0;
    #1;
    check("hit1_cnt", hit_cnt, 16'd1);
    check("idle_dout", data_out, 16'h0000);

    // Store to a cached word writes through and updates the line.
    start(1'b1, 16'h0040, 16'h1234);
    check("st1_stall_idle", 16'(stall), 16'd1);
    tick();
    check("st1_req", 16'(mem_req), 16'd1);
    check("st1_wr", 16'(mem_wr), 16'd1);
    check("st1_wdata", mem_wdata, 16'h1234);
    check("st1_addr", mem_addr, 16'h0040);
    ack(16'h0000);
    check("st1_resp_stall", 16'(stall), 16'd0);
    check("st1_resp_dout", data_out, 16'h0000);
    finish_resp();
    start(1'b0, 16'h0040, 16'h0);
    check("hit2_stall", 16'(stall), 16'd0);
    check("hit2_dout", data_out, 16'h1234);
    tick();
    enable = 1'b0;
    #1;
    check("hit2_cnt", hit_cnt, 16'd2);

    // Store to an uncached address must not allocate or disturb the resident line.
    start(1'b1, 16'h0200, 16'h7777);
    tick();
    check("st2_addr", mem_addr, 16'h0200);
    check("st2_wdata", mem_wdata, 16'h7777);
    ack(16'h0000);
    finish_resp();
    start(1'b0, 16'h0040, 16'h0);
    check("hit3_dout", data_out, 16'h1234);
    tick();
    enable = 1'b0;
    #1;
    check("hit3_cnt", hit_cnt, 16'd3);
    start(1'b0, 16'h0200, 16'h0);
    check("noalloc_stall", 16'(stall), 16'd1);
    tick();
    check("noalloc_miss", miss_cnt, 16'd2);
    ack(16'h5555);
    check("noalloc_dout", data_out, 16'h5555);
    finish_resp();

    // Delayed ack: 0040 was evicted by 0200; ack arrives in the fifth wait cycle.
    start(1'b0, 16'h0040, 16'h0);
    stall_cycles = 0;
    if (stall) stall_cycles++;
    tick();
    for (int i = 1; i <= 4; i++) begin
      check("dly_addr", mem_addr, 16'h0040);
      check("dly_req", 16'(mem_req), 16'd1);
      if (stall) stall_cycles++;
      tick();
    end
    check("dly_addr5", mem_addr, 16'h0040);
    if (stall) stall_cycles++;
    ack(16'hA040);
    if (stall) stall_cycles++;
    check("dly_stall_cycles", 16'(stall_cycles), 16'd6);
    check("dly_dout", data_out, 16'hA040);
    check("dly_miss", miss_cnt, 16'd3);
    finish_resp();

    // Conflict load 0060 (same index) evicts 0040.
    start(1'b0, 16'h0060, 16'h0);
    check("conf_stall", 16'(stall), 16'd1);
    tick();
    check("conf_addr", mem_addr, 16'h0060);
    ack(16'h6060);
    check("conf_dout", data_out, 16'h6060);
    finish_resp();
    start(1'b0, 16'h0040, 16'h0);
    check("evict_stall", 16'(stall), 16'd1);
    tick();
    ack(16'h4040);
    check("evict_dout", data_out, 16'h4040);
    check("evict_miss", miss_cnt, 16'd5);
    finish_resp();

    // Hold a hitting load long enough to saturate the hit counter.
    start(1'b0, 16'h0040, 16'h0);
    check("sat_dout", data_out, 16'h4040);
    repeat (65540) tick();
    enable = 1'b0;
    #1;
    check("sat_hit", hit_cnt, 16'hFFFF);
    check("sat_miss", miss_cnt, 16'd5);

    // Reset during RD_WAIT abandons the transaction; a late ack is ignored.
    start(1'b0, 16'h0080, 16'h0);
    tick();
    check("rw_req", 16'(mem_req), 16'd1);
    rst = 1'b0;
    enable = 1'b0;
    tick();
    check("rw_rst_req", 16'(mem_req), 16'd0);
    check("rw_rst_stall", 16'(stall), 16'd0);
    check("rw_rst_hit", hit_cnt, 16'd0);
    check("rw_rst_miss", miss_cnt, 16'd0);
    rst = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 16'hDEAD;
    tick();
    mem_ack = 1'b0;
    #1;
    check("late_ack_req", 16'(mem_req), 16'd0);
    check("late_ack_stall", 16'(stall), 16'd0);
    start(1'b0, 16'h0080, 16'h0);
    check("inval80_stall", 16'(stall), 16'd1);
    check("inval80_dout", data_out, 16'h0000);
    addr = 16'h0040;
    #1;
    check("inval40_stall", 16'(stall), 16'd1);
    tick();
    check("post_rst_miss", miss_cnt, 16'd1);
    check("post_rst_addr", mem_addr, 16'h0040);
    ack(16'h0101);
    check("post_rst_dout", data_out, 16'h0101);
    finish_resp();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter: LINES, 16, number of direct-mapped one-word cache lines (power of two, 2..64).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-low (rst=0 sampled at clk edge resets block).
REQ-004 Port: enable  input  1  memory-stage request valid.
REQ-005 Port: wr  input  1  1=store, 0=load; qualified by enable.
REQ-006 Port: addr  input  16  byte address; addr[0] ignored (word access).
REQ-007 Port: data_in  input  16  store data.
REQ-008 Port: data_out  output  16  load data, valid when enable=1, wr=0, stall=0.
REQ-009 Port: stall  output  1  pipeline hold; CPU keeps enable/wr/addr/data_in stable while 1.
REQ-010 Port: mem_req  output  1  main-memory request, held until acknowledged.
REQ-011 Port: mem_wr  output  1  main-memory write strobe, valid with mem_req.
REQ-012 Port: mem_addr  output  16  main-memory word address (bit 0 = 0), valid with mem_req.
REQ-013 Port: mem_wdata  output  16  main-memory write data, valid with mem_req.
REQ-014 Port: mem_rdata  input  16  main-memory read data, valid with mem_ack.
REQ-015 Port: mem_ack  input  1  one-cycle completion pulse from main memory.
REQ-016 Port: hit_cnt  output  16  count of load hits, saturating at 16'hFFFF.
REQ-017 Port: miss_cnt  output  16  count of load misses, saturating at 16'hFFFF.

Function
REQ-018 Address split: index = addr[log2(LINES):1], tag = addr[15:log2(LINES)+1].
REQ-019 States: IDLE, RD_WAIT, WR_WAIT, RESP.
REQ-020 IDLE, enable=0: stall=0, mem_req=0, stay IDLE.
REQ-021 IDLE, load hit (valid & tag match): data_out = line data combinationally, stall=0, hit_cnt+1, stay IDLE.
REQ-022 IDLE, load miss: stall=1, capture addr, miss_cnt+1, go RD_WAIT.
REQ-023 IDLE, store: stall=1, capture addr/data_in, go WR_WAIT; write-through, no write-allocate.
REQ-024 RD_WAIT/WR_WAIT: mem_req=1, stall=1, mem_addr/mem_wdata/mem_wr from captured values, stable until mem_ack.
REQ-025 RD_WAIT with mem_ack=1: write mem_rdata into line, set valid, set tag, register mem_rdata, go RESP.
REQ-026 WR_WAIT with mem_ack=1: if line valid and tag matches, update line data; else line unchanged; go RESP.
REQ-027 RESP: stall=0, mem_req=0, data_out = registered read data (loads), go IDLE unconditionally; request in RESP cycle not re-evaluated.
REQ-028 Minimum miss/store latency: stall high 2 cycles (IDLE decision + one wait cycle) when mem_ack arrives in first wait cycle; each extra cycle without mem_ack adds one.
REQ-029 mem_ack in IDLE or RESP ignored; no state or array change.
REQ-030 enable dropping during a wait state does not abort; transaction completes.
REQ-031 Counters saturate; no wrap to 0.
REQ-032 data_out = 16'h0000 whenever not in a load-valid condition.

Reset
REQ-033 rst=0 at edge: state IDLE, all valid bits 0, mem_req=0, hit_cnt=0, miss_cnt=0, captured registers 0.
REQ-034 Reset mid-transaction abandons it; mem_req deasserts the cycle after reset is sampled; a later mem_ack is ignored per REQ-029.
REQ-035 Tag/data array contents need not reset; only valid bits do.

Structure
REQ-036 Shared package holds state enum, ADDR_W=16, DATA_W=16, default LINES.
REQ-037 One sub-module, dcache_array: valid/tag/data storage with one combinational read port and one synchronous write port.

Verification
REQ-038 After reset, load addr 16'h0040 -> stall 1 cycle+, mem_req/mem_addr=16'h0040; ack with rdata 16'hBEEF -> RESP data_out=16'hBEEF, miss_cnt=1.
REQ-039 Repeat load 16'h0040 -> stall=0 same cycle, data_out=16'hBEEF, hit_cnt=1, no mem_req.
REQ-040 Store 16'h1234 to 16'h0040 -> mem_req, mem_wr=1, mem_wdata=16'h1234; after ack, load 16'h0040 hits with 16'h1234.
REQ-041 Store to uncached 16'h0200 then load 16'h0200 -> load misses (no allocate), miss_cnt increments.
REQ-042 Load miss, mem_ack delayed 5 cycles -> stall held 6 cycles, mem_addr stable throughout; conflict load 16'h0060 (LINES=16) evicts 16'h0040.
REQ-043 Assert rst=0 during RD_WAIT, then mem_ack -> state IDLE, mem_req=0, all lines invalid, counters 0, ack ignored.
